mem_bus_arbiter: RTL and testbench

//  Shares one physical memory port between the core's ibus and dbus in the SoC top.

---
 rtl/mem_bus_arbiter_pkg.sv | 25 ++
 rtl/mem_bus_arbiter_prio_sel.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, state encoding and counter-sizing helper for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned MaskW = 4;

    // Read data handed back when the watchdog aborts a transaction.
    localparam logic [DataW-1:0] ArbErrData = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } arb_state_e;

    // Bits needed to count 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val == 0) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_prio_sel.sv
// Fixed-priority winner select (dbus first) with an ibus starvation guard.
// Purely combinational; the top loads starve_cnt_o only on a grant.
module mem_bus_arbiter_prio_sel
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned StarveMax = 4,
    parameter int unsigned CntW      = cnt_width(StarveMax)
) (
    input  logic            ibus_req_i,
    input  logic            dbus_req_i,
    input  logic [CntW-1:0] starve_cnt_i,
    output logic            grant_o,
    output logic            grant_dbus_o,
    output logic [CntW-1:0] starve_cnt_o
);

    localparam logic [CntW-1:0] StarveLim = CntW'(StarveMax);

    logic ibus_forced;

    // Pick the winner and compute the starve count to load with this grant.
    always_comb begin
        ibus_forced  = ibus_req_i && (starve_cnt_i == StarveLim);
        grant_o      = ibus_req_i | dbus_req_i;
        grant_dbus_o = dbus_req_i && !ibus_forced;
        starve_cnt_o = '0;
        // Only a dbus win over a waiting ibus counts towards starvation.
        if (grant_dbus_o && ibus_req_i) begin
            if (starve_cnt_i != StarveLim) begin
                starve_cnt_o = starve_cnt_i + CntW'(1);
            end else begin
                starve_cnt_o = starve_cnt_i;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between ibus and dbus, one transaction in flight.
// IDLE arbitrates, BUSY holds the request and runs the watchdog, DONE pulses ready for one cycle.
// Every output is a flop; nothing passes combinationally from input to output.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned       StarveMax = 4,
    parameter int unsigned       Timeout   = 256,
    parameter logic [DataW-1:0]  ErrData   = ArbErrData
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ibus_req_i,
    input  logic             ibus_we_i,
    input  logic [AddrW-1:0] ibus_addr_i,
    input  logic [DataW-1:0] ibus_data_i,
    input  logic [MaskW-1:0] ibus_mask_i,
    output logic [DataW-1:0] ibus_data_o,
    output logic             ibus_ready_o,
    input  logic             dbus_req_i,
    input  logic             dbus_we_i,
    input  logic [AddrW-1:0] dbus_addr_i,
    input  logic [DataW-1:0] dbus_data_i,
    input  logic [MaskW-1:0] dbus_mask_i,
    output logic [DataW-1:0] dbus_data_o,
    output logic             dbus_ready_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_data_o,
    output logic [MaskW-1:0] mem_mask_o,
    input  logic [DataW-1:0] mem_data_i,
    input  logic             mem_ready_i,
    output logic             bus_err_o
);

    localparam int unsigned StarveW = cnt_width(StarveMax);
    localparam int unsigned WaitW   = cnt_width(Timeout);
    localparam bit          WdogEn  = (Timeout != 0);
    localparam logic [WaitW-1:0] WaitLast = (Timeout == 0) ? '0 : WaitW'(Timeout - 1);

    arb_state_e         state_q;
    logic [StarveW-1:0] starve_q;
    logic [StarveW-1:0] starve_d;
    logic [WaitW-1:0]   wait_q;
    logic               gnt_dbus_q;

    logic               mem_req_q;
    logic               mem_we_q;
    logic [AddrW-1:0]   mem_addr_q;
    logic [DataW-1:0]   mem_data_q;
    logic [MaskW-1:0]   mem_mask_q;
    logic               ibus_ready_q;
    logic               dbus_ready_q;
    logic [DataW-1:0]   ibus_data_q;
    logic [DataW-1:0]   dbus_data_q;
    logic               bus_err_q;

    logic               grant;
    logic               grant_dbus;
    logic               finish;
    logic [DataW-1:0]   done_data;

    mem_bus_arbiter_prio_sel #(
        .StarveMax (StarveMax),
        .CntW      (StarveW)
    ) u_prio_sel (
        .ibus_req_i   (ibus_req_i),
        .dbus_req_i   (dbus_req_i),
        .starve_cnt_i (starve_q),
        .grant_o      (grant),
        .grant_dbus_o (grant_dbus),
        .starve_cnt_o (starve_d)
    );

    // BUSY ends on memory ready or watchdog expiry; ready wins when both coincide.
    always_comb begin
        finish    = mem_ready_i || (WdogEn && (wait_q == WaitLast));
        done_data = mem_ready_i ? mem_data_i : ErrData;
    end

    // Arbiter FSM with registered memory fields and completion outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            starve_q     <= '0;
            wait_q       <= '0;
            gnt_dbus_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_mask_q   <= '0;
            ibus_ready_q <= 1'b0;
            dbus_ready_q <= 1'b0;
            ibus_data_q  <= '0;
            dbus_data_q  <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_q    <= StBusy;
                        starve_q   <= starve_d;
                        wait_q     <= '0;
                        gnt_dbus_q <= grant_dbus;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= grant_dbus ? dbus_we_i   : ibus_we_i;
                        mem_addr_q <= grant_dbus ? dbus_addr_i : ibus_addr_i;
                        mem_data_q <= grant_dbus ? dbus_data_i : ibus_data_i;
                        mem_mask_q <= grant_dbus ? dbus_mask_i : ibus_mask_i;
                    end
                end
                StBusy: begin
                    wait_q <= wait_q + WaitW'(1);
                    if (finish) begin
                        state_q   <= StDone;
                        mem_req_q <= 1'b0;
                        bus_err_q <= !mem_ready_i;
                        if (gnt_dbus_q) begin
                            dbus_ready_q <= 1'b1;
                            dbus_data_q  <= done_data;
                        end else begin
                            ibus_ready_q <= 1'b1;
                            ibus_data_q  <= done_data;
                        end
                    end
                end
                StDone: begin
                    // No arbitration here so a requester reacting to ready is never granted twice.
                    state_q      <= StIdle;
                    ibus_ready_q <= 1'b0;
                    dbus_ready_q <= 1'b0;
                    ibus_data_q  <= '0;
                    dbus_data_q  <= '0;
                    bus_err_q    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_mask_o   = mem_mask_q;
    assign ibus_ready_o = ibus_ready_q;
    assign dbus_ready_o = dbus_ready_q;
    assign ibus_data_o  = ibus_data_q;
    assign dbus_data_o  = dbus_data_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requests, a latency-programmable memory
// responder, and a monitor that pops expectations whenever a ready pulse appears.
module tb_mem_bus_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    typedef struct {
        bit          dbus;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        bit          chk_data;
        bit          err;
        int          lat;
        int          len;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ibus_req_i = 1'b0, ibus_we_i = 1'b0;
    logic [31:0] ibus_addr_i = '0, ibus_data_i = '0;
    logic [3:0]  ibus_mask_i = '0;
    logic        dbus_req_i = 1'b0, dbus_we_i = 1'b0;
    logic [31:0] dbus_addr_i = '0, dbus_data_i = '0;
    logic [3:0]  dbus_mask_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        resp_ready = 1'b0;
    logic        spur = 1'b0;
    wire         mem_ready_i = resp_ready | spur;

    wire [31:0]  ibus_data_o, dbus_data_o, mem_addr_o, mem_data_o;
    wire         ibus_ready_o, dbus_ready_o, mem_req_o, mem_we_o, bus_err_o;
    wire [3:0]   mem_mask_o;

    req_t iq[$];
    req_t dq[$];
    exp_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ib_issue = 0, db_issue = 0;
    bit   ib_busy = 0, db_busy = 0;
    int   lat = 0;
    bit   stall = 0;
    int   age = 0;
    int   last_len = 0;

    mem_bus_arbiter #(
        .StarveMax (4),
        .Timeout   (8),
        .ErrData   (32'hDEAD_BEEF)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ibus_req_i   (ibus_req_i),
        .ibus_we_i    (ibus_we_i),
        .ibus_addr_i  (ibus_addr_i),
        .ibus_data_i  (ibus_data_i),
        .ibus_mask_i  (ibus_mask_i),
        .ibus_data_o  (ibus_data_o),
        .ibus_ready_o (ibus_ready_o),
        .dbus_req_i   (dbus_req_i),
        .dbus_we_i    (dbus_we_i),
        .dbus_addr_i  (dbus_addr_i),
        .dbus_data_i  (dbus_data_i),
        .dbus_mask_i  (dbus_mask_i),
        .dbus_data_o  (dbus_data_o),
        .dbus_ready_o (dbus_ready_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_mask_o   (mem_mask_o),
        .mem_data_i   (mem_data_i),
        .mem_ready_i  (mem_ready_i),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic issue(input bit is_d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input logic [31:0] rdata, input bit chk_data, input bit err,
                         input int lat_c, input int len);
        req_t r;
        exp_t e;
        r.we = we; r.addr = addr; r.wdata = wdata; r.mask = mask;
        e.dbus = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.mask = mask;
        e.rdata = rdata; e.chk_data = chk_data; e.err = err; e.lat = lat_c; e.len = len;
        if (is_d) dq.push_back(r);
        else iq.push_back(r);
        exp_q.push_back(e);
    endtask

    task automatic set_bus(input bit is_d, input logic req, input req_t r);
        if (is_d) begin
            dbus_req_i = req; dbus_we_i = r.we; dbus_addr_i = r.addr;
            dbus_data_i = r.wdata; dbus_mask_i = r.mask;
        end else begin
            ibus_req_i = req; ibus_we_i = r.we; ibus_addr_i = r.addr;
            ibus_data_i = r.wdata; ibus_mask_i = r.mask;
        end
    endtask

    // Requester: holds req with stable fields until ready, renews in the DONE cycle.
    task automatic drive_bus(input bit is_d);
        req_t r = '{we: 1'b0, addr: '0, wdata: '0, mask: '0};
        int   guard;
        bit   rdy;
        forever begin
            if (rst_ni && (is_d ? dq.size() != 0 : iq.size() != 0)) begin
                r = is_d ? dq.pop_front() : iq.pop_front();
                if (is_d) begin db_busy = 1; db_issue = cyc; end
                else begin ib_busy = 1; ib_issue = cyc; end
                set_bus(is_d, 1'b1, r);
                guard = 0;
                do begin
                    @(posedge clk_i); #1;
                    guard++;
                    rdy = is_d ? dbus_ready_o : ibus_ready_o;
                end while (!rdy && rst_ni && guard < 100);
                if (guard >= 100) begin
                    checks++;
                    errors++;
                    $display("FAIL req_served bus=%0d got=no ready required=ready within 100", is_d);
                end
                set_bus(is_d, 1'b0, r);
                if (is_d) db_busy = 0;
                else ib_busy = 0;
            end else begin
                set_bus(is_d, 1'b0, r);
                @(posedge clk_i); #1;
            end
        end
    endtask

    initial drive_bus(1'b0);
    initial drive_bus(1'b1);

    // Memory responder: answers L cycles after the request rises, unless stalled.
    initial begin
        forever begin
            @(posedge clk_i); #1;
            if (mem_req_o) begin
                chk("grant_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("mem_we", 32'(mem_we_o), 32'(exp_q[0].we));
                    chk("mem_addr", mem_addr_o, exp_q[0].addr);
                    chk("mem_wdata", mem_data_o, exp_q[0].wdata);
                    chk("mem_mask", 32'(mem_mask_o), 32'(exp_q[0].mask));
                end
                resp_ready = !stall && (age == lat);
                mem_data_i = ~mem_addr_o;
                age++;
            end else begin
                if (age != 0) last_len = age;
                age = 0;
                resp_ready = 1'b0;
            end
        end
    end

    // Monitor: pops one expectation per ready pulse; outside DONE all data/err must be 0.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni) begin
            if (ibus_ready_o || dbus_ready_o) begin
                chk("one_ready", 32'(ibus_ready_o & dbus_ready_o), 32'd0);
                chk("ready_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ready_port", 32'(dbus_ready_o), 32'(e.dbus));
                    chk("other_data", e.dbus ? ibus_data_o : dbus_data_o, 32'd0);
                    if (e.chk_data) chk("rdata", e.dbus ? dbus_data_o : ibus_data_o, e.rdata);
                    chk("bus_err", 32'(bus_err_o), 32'(e.err));
                    if (e.lat >= 0) chk("latency", 32'(cyc - (e.dbus ? db_issue : ib_issue)),
                                        32'(e.lat));
                    chk("mem_req_len", 32'(last_len), 32'(e.len));
                end
            end else begin
                chk("idle_data", ibus_data_o | dbus_data_o, 32'd0);
                chk("idle_err", 32'(bus_err_o), 32'd0);
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk_i); #2;
            done = (exp_q.size() == 0) && (iq.size() == 0) && (dq.size() == 0) &&
                   !ib_busy && !db_busy;
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=still running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_ibus_ready", 32'(ibus_ready_o), 32'd0);
        chk("rst_dbus_ready", 32'(dbus_ready_o), 32'd0);
        chk("rst_bus_err", 32'(bus_err_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // 1: single ibus read, L=0
        issue(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hFFFF_FEFF, 1, 0, 2, 1);
        wait_idle(50);

        // 2: both held; four dbus grants, then ibus forced, then the last dbus
        issue(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'hF, 32'hDFFF_FFFF, 1, 0, -1, 1);
        issue(1'b1, 1'b0, 32'h2000_0004, 32'h0, 4'hF, 32'hDFFF_FFFB, 1, 0, -1, 1);
        issue(1'b1, 1'b0, 32'h2000_0008, 32'h0, 4'hF, 32'hDFFF_FFF7, 1, 0, -1, 1);
        issue(1'b1, 1'b0, 32'h2000_000C, 32'h0, 4'hF, 32'hDFFF_FFF3, 1, 0, -1, 1);
        issue(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'hFFFF_FDFF, 1, 0, -1, 1);
        issue(1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'hF, 32'hDFFF_FFEF, 1, 0, -1, 1);
        wait_idle(200);

        // 3: dbus write, L=3; fields held 4 cycles, no second grant afterwards
        lat = 3;
        issue(1'b1, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 32'h0, 0, 0, 5, 4);
        wait_idle(50);
        repeat (5) @(posedge clk_i);
        lat = 0;

        // 4: watchdog abort after 8 cycles of mem_req
        stall = 1;
        issue(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, 1, 9, 8);
        wait_idle(50);
        #1;
        chk("after_abort_req", 32'(mem_req_o), 32'd0);

        // 5: async reset mid-BUSY drops mem_req at once, no ready pulse
        issue(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 32'h0, 0, 0, -1, 0);
        for (int i = 0; i < 20 && !mem_req_o; i++) @(posedge clk_i);
        repeat (2) @(posedge clk_i);
        #2;
        chk("busy_before_rst", 32'(mem_req_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst_drop_req", 32'(mem_req_o), 32'd0);
        chk("rst_no_iready", 32'(ibus_ready_o), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        stall = 0;
        issue(1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 32'hBFFF_FFFF, 1, 0, 2, 1);
        wait_idle(50);

        // 6: stray mem_ready in IDLE is ignored
        @(negedge clk_i);
        spur = 1'b1;
        @(negedge clk_i);
        spur = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            chk("spur_iready", 32'(ibus_ready_o), 32'd0);
            chk("spur_dready", 32'(dbus_ready_o), 32'd0);
            chk("spur_err", 32'(bus_err_o), 32'd0);
            chk("spur_req", 32'(mem_req_o), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
